// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: runs one conv job end to end (src -> conv input, start, wait, conv result -> dst).
// Optional WAIT-state timeout is compiled in when CONV_SEQ_TIMEOUT_EN is defined.
module conv_job_sequencer #(
  parameter int DSIZE = 1024,
`ifdef CONV_SEQ_TIMEOUT_EN
  parameter int DONE_TIMEOUT = 65535,
`endif
  localparam int ADDR_W = $clog2(DSIZE) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_in_words,
  input  logic [ADDR_W-1:0] job_out_count,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [31:0]       src_data,
  output logic              mi_wr,
  output logic [ADDR_W-1:0] mi_addr,
  output logic [31:0]       mi_data,
  output logic              conv_start,
  input  logic              conv_done,
  output logic [ADDR_W-1:0] mo_addr,
  input  logic [31:0]       mo_data,
  output logic              dst_wr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [31:0]       dst_data,
  output logic              busy,
  output logic              job_done,
  output logic              err_timeout
);

  localparam logic [ADDR_W-1:0] MAX_WORDS = ADDR_W'(DSIZE / 4);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN, S_FIN
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic [ADDR_W-1:0] n_words, m_words;
  logic [ADDR_W-1:0] in_clamped;
  logic [ADDR_W-1:0] wr_idx;
  logic              accept;
  logic              timeout_hit;

  assign accept     = (state == S_IDLE) && job_valid;
  assign in_clamped = (job_in_words > MAX_WORDS) ? MAX_WORDS : job_in_words;
  // The write in LOAD always trails the read issued one cycle earlier.
  assign wr_idx     = cnt - ONE;

  assign job_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign conv_start = (state == S_START);
  assign job_done   = (state == S_FIN);

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(DONE_TIMEOUT + 1);

  logic [TO_W-1:0] wait_cnt;
  logic            err_flag;

  assign timeout_hit = (state == S_WAIT) && !conv_done &&
                       (wait_cnt == TO_W'(DONE_TIMEOUT - 1));
  assign err_timeout = err_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_flag <= 1'b0;
    end else begin
      if (state != S_WAIT) wait_cnt <= '0;
      else                 wait_cnt <= wait_cnt + TO_W'(1);
      if (accept)           err_flag <= 1'b0;
      else if (timeout_hit) err_flag <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      n_words <= '0;
      m_words <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        n_words <= in_clamped;
        m_words <= job_out_count;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    src_rd     = 1'b0;
    src_addr   = '0;
    mi_wr      = 1'b0;
    mi_addr    = '0;
    mi_data    = '0;
    mo_addr    = '0;
    dst_wr     = 1'b0;
    dst_addr   = '0;
    dst_data   = '0;
    case (state)
      S_IDLE: begin
        if (job_valid) begin
          cnt_next   = '0;
          state_next = (in_clamped == '0) ? S_START : S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt < n_words) begin
          src_rd   = 1'b1;
          src_addr = cnt;
        end
        if (cnt != '0) begin
          mi_wr   = 1'b1;
          mi_addr = wr_idx << 2;
          mi_data = src_data;
        end
        if (cnt == n_words) begin
          cnt_next   = '0;
          state_next = S_START;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      S_START: state_next = S_WAIT;
      S_WAIT: begin
        if (conv_done) begin
          cnt_next   = '0;
          state_next = (m_words == '0) ? S_FIN : S_DRAIN;
        end else if (timeout_hit) begin
          state_next = S_FIN;
        end
      end
      S_DRAIN: begin
        mo_addr  = cnt;
        dst_wr   = 1'b1;
        dst_addr = cnt;
        dst_data = mo_data;
        if (cnt == m_words - ONE) begin
          cnt_next   = '0;
          state_next = S_FIN;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Bench for conv_job_sequencer: source/conv/result models plus job-level reference checks.
// Build with CONV_SEQ_TIMEOUT_EN defined to also exercise the WAIT timeout path.
module tb_conv_job_sequencer;
  localparam int DSIZE = 1024;
  localparam int AW    = 11;
  localparam int MAXW  = 256;
`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int DT    = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [AW-1:0] job_in_words = '0;
  logic [AW-1:0] job_out_count = '0;
  logic          src_rd;
  logic [AW-1:0] src_addr;
  logic [31:0]   src_data = '0;
  logic          mi_wr;
  logic [AW-1:0] mi_addr;
  logic [31:0]   mi_data;
  logic          conv_start;
  logic          conv_done = 1'b0;
  logic [AW-1:0] mo_addr;
  logic [31:0]   mo_data;
  logic          dst_wr;
  logic [AW-1:0] dst_addr;
  logic [31:0]   dst_data;
  logic          busy;
  logic          job_done;
  logic          err_timeout;

  always #5 clk = ~clk;

  conv_job_sequencer #(
    .DSIZE(DSIZE)
`ifdef CONV_SEQ_TIMEOUT_EN
    , .DONE_TIMEOUT(DT)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_in_words(job_in_words), .job_out_count(job_out_count),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .mi_wr(mi_wr), .mi_addr(mi_addr), .mi_data(mi_data),
    .conv_start(conv_start), .conv_done(conv_done),
    .mo_addr(mo_addr), .mo_data(mo_data),
    .dst_wr(dst_wr), .dst_addr(dst_addr), .dst_data(dst_data),
    .busy(busy), .job_done(job_done), .err_timeout(err_timeout)
  );

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    int n;
    int m;
    int d;
    bit sp;
    int exp_cycles;
  } vec_t;

  ev_t         rd_q[$];
  ev_t         mi_q[$];
  ev_t         dst_q[$];
  logic [31:0] src_mem [0:255];
  logic [31:0] mo_mem  [0:2047];

  assign mo_data = mo_mem[mo_addr];

  int cyc = 0, accept_total = 0, accept_cyc = 0;
  int start_cnt = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0;
  int done_delay = 1, done_timer = 0;
  bit drop_pending = 1'b0;
  int n_checks = 0, n_fail = 0;

  // Mid-cycle monitor; also plays the source memory (1-cycle read latency) and the conv engine.
  // conv keeps done high through the START cycle and drops it one cycle later.
  always @(negedge clk) begin
    cyc++;
    if (job_valid && job_ready) begin
      accept_total++;
      accept_cyc = cyc;
      rd_q.delete();
      mi_q.delete();
      dst_q.delete();
      start_cnt = 0;
      done_cnt  = 0;
    end
    if (src_rd)     rd_q.push_back('{cyc, int'(src_addr), 32'h0});
    if (mi_wr)      mi_q.push_back('{cyc, int'(mi_addr), mi_data});
    if (dst_wr)     dst_q.push_back('{cyc, int'(dst_addr), dst_data});
    if (conv_start) begin start_cnt++; start_cyc = cyc; end
    if (job_done)   begin done_cnt++;  done_cyc  = cyc; end
    src_data = src_rd ? src_mem[src_addr[7:0]] : 32'hDEAD_BEEF;
    if (conv_start) begin
      done_timer   = done_delay;
      drop_pending = 1'b1;
    end else begin
      if (drop_pending) begin
        conv_done    = 1'b0;
        drop_pending = 1'b0;
      end
      if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) conv_done = 1'b1;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // Issues one job and checks every observable against the job-level rules.
  task automatic run_job(input int n, input int m, input int d, input bit spurious,
                         input int exp_cycles, input bit exp_to);
    int nn, em, a0, errs, s;
    nn = (n > MAXW) ? MAXW : n;
    em = exp_to ? 0 : m;
    done_delay = d;
    a0 = accept_total;
    @(posedge clk); #1;
    job_in_words  = AW'(n);
    job_out_count = AW'(m);
    job_valid     = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      job_valid = 1'b0;
      if (done_cnt != 0) break;
      if (spurious && busy && !job_done && (i % 3 == 1)) job_valid = 1'b1;
    end
    check("accept_once", accept_total - a0, 1);
    check("ready_after_job", job_ready, 1);
    check("busy_after_job", busy, 0);
    check("job_done_pulses", done_cnt, 1);
    check("conv_start_pulses", start_cnt, 1);
    check("total_cycles", done_cyc - accept_cyc + 1, exp_cycles);
    s = accept_cyc + 1 + ((nn != 0) ? nn + 1 : 0);
    check("start_cycle", start_cyc, s);

    errs = 0;
    for (int k = 0; k < nn; k++)
      if (k >= rd_q.size() || rd_q[k].addr != k || rd_q[k].cyc != accept_cyc + 1 + k) errs++;
    check("src_rd_count", rd_q.size(), nn);
    check("src_rd_stream_errs", errs, 0);

    errs = 0;
    for (int k = 0; k < nn; k++)
      if (k >= mi_q.size() || mi_q[k].addr != 4 * k || mi_q[k].data != src_mem[k] ||
          mi_q[k].cyc != accept_cyc + 2 + k) errs++;
    check("mi_wr_count", mi_q.size(), nn);
    check("mi_wr_stream_errs", errs, 0);

    errs = 0;
    for (int j = 0; j < em; j++)
      if (j >= dst_q.size() || dst_q[j].addr != j || dst_q[j].data != mo_mem[j] ||
          dst_q[j].cyc != s + d + 1 + j) errs++;
    check("dst_wr_count", dst_q.size(), em);
    check("dst_wr_stream_errs", errs, 0);
    check("err_timeout", err_timeout, exp_to);
    $display("job n=%0d m=%0d d=%0d: %0d mi writes, %0d dst writes, %0d cycles",
             n, m, d, mi_q.size(), dst_q.size(), done_cyc - accept_cyc + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    bit   found;
    int   n, m, d, nn;
    bit   sp;

    for (int i = 0; i < 256; i++)  src_mem[i] = $urandom;
    for (int i = 0; i < 2048; i++) mo_mem[i]  = $urandom;

    vecs[0] = '{256, 500, 40, 1'b0, 800};
    vecs[1] = '{0,   0,   5,  1'b0, 8};
    vecs[2] = '{1,   1,   2,  1'b1, 8};
    vecs[3] = '{300, 3,   3,  1'b1, 266};
    vecs[4] = '{10,  0,   4,  1'b0, 18};
    vecs[5] = '{0,   7,   1,  1'b1, 11};

    // Reset state
    #12;
    check("rst_job_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_src_rd", src_rd, 0);
    check("rst_mi_wr", mi_wr, 0);
    check("rst_dst_wr", dst_wr, 0);
    check("rst_conv_start", conv_start, 0);
    check("rst_job_done", job_done, 0);
    check("rst_err_timeout", err_timeout, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int v = 0; v < 6; v++)
      run_job(vecs[v].n, vecs[v].m, vecs[v].d, vecs[v].sp, vecs[v].exp_cycles, 1'b0);

    // Asynchronous reset in the middle of LOAD, then a fresh job restarting at address 0
    done_delay = 3;
    @(posedge clk); #1;
    job_in_words  = AW'(200);
    job_out_count = AW'(5);
    job_valid     = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      job_valid = 1'b0;
      if (src_rd && src_addr == AW'(100)) begin found = 1'b1; break; end
    end
    check("reached_load_k100", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_src_rd", src_rd, 0);
    check("abort_mi_wr", mi_wr, 0);
    check("abort_conv_start", conv_start, 0);
    check("abort_dst_wr", dst_wr, 0);
    check("abort_job_done", job_done, 0);
    check("abort_busy", busy, 0);
    check("abort_job_ready", job_ready, 1);
    @(posedge clk); #2 rst_n = 1'b1;
    run_job(4, 2, 3, 1'b0, 1 + 5 + 1 + 3 + 2 + 1, 1'b0);

`ifdef CONV_SEQ_TIMEOUT_EN
    // conv_done never rises: DRAIN skipped, error flagged, cleared by the next accept
    run_job(2, 4, -1, 1'b0, 1 + 3 + 1 + DT + 0 + 1, 1'b1);
    run_job(3, 2, 2, 1'b0, 1 + 4 + 1 + 2 + 2 + 1, 1'b0);
`endif

    // Randomized jobs against the cycle/transfer rules
    for (int r = 0; r < 6; r++) begin
      n  = $urandom_range(0, 270);
      m  = $urandom_range(0, 40);
      d  = $urandom_range(1, 12);
      sp = 1'($urandom_range(0, 1));
      nn = (n > MAXW) ? MAXW : n;
      run_job(n, m, d, sp, 1 + ((nn != 0) ? nn + 1 : 0) + 1 + d + m + 1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
